// File: rtl/cnn_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cnn_pkg                                                            |
// | Shared defaults and FSM encoding for cnn_img_loader / cnn_top.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package cnn_pkg;

  localparam int IMG_SIZE_DEF = 64;
  localparam int DATA_W_DEF   = 32;
  localparam int OUT_W_DEF    = 32;
  localparam int TIMEOUT_DEF  = 1024;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } cnn_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_frame_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cnn_frame_buf                                                      |
// | IMG_SIZE x DATA_W pixel store, one write port, flat read bus.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module cnn_frame_buf
  import cnn_pkg::*;
#(
  parameter int IMG_SIZE = IMG_SIZE_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = cnt_width(IMG_SIZE)
) (
  input  logic                       clk,
  input  logic                       i_wr_en,
  input  logic [ADDR_W-1:0]          i_wr_addr,
  input  logic [DATA_W-1:0]          i_wr_data,
  output logic [IMG_SIZE*DATA_W-1:0] o_rd_bus
);

  // Storage is intentionally not reset; contents are only meaningful
  // once a full frame has been written.
  for (genvar k = 0; k < IMG_SIZE; k++) begin : g_slot
    logic [DATA_W-1:0] r_pix;

    always_ff @(posedge clk) begin
      if (i_wr_en && (i_wr_addr == ADDR_W'(k))) begin
        r_pix <= i_wr_data;
      end
    end

    assign o_rd_bus[k*DATA_W +: DATA_W] = r_pix;
  end

endmodule
`default_nettype wire

// File: rtl/cnn_img_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cnn_img_loader                                                     |
// | Collects a pixel frame, runs cnn_top with timeout, holds result.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module cnn_img_loader
  import cnn_pkg::*;
#(
  parameter int IMG_SIZE = IMG_SIZE_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int OUT_W    = OUT_W_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          pix_data,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  output logic [IMG_SIZE*DATA_W-1:0] img_bus,
  output logic                       cnn_enable,
  input  logic                       cnn_done,
  input  logic [OUT_W-1:0]           cnn_value,
  output logic [OUT_W-1:0]           res_value,
  output logic                       res_err,
  output logic                       res_valid,
  input  logic                       res_ready
);

  localparam int WR_W  = cnt_width(IMG_SIZE);
  localparam int TMO_W = cnt_width(TIMEOUT);

  localparam logic [1:0]       c_st_fill  = ST_FILL;
  localparam logic [1:0]       c_st_run   = ST_RUN;
  localparam logic [1:0]       c_st_hold  = ST_HOLD;
  localparam logic [WR_W-1:0]  c_wr_last  = WR_W'(IMG_SIZE - 1);
  localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT - 1);

  logic [1:0]       r_state;
  logic [WR_W-1:0]  r_wr_cnt;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [OUT_W-1:0] r_res_value;
  logic             r_res_err;

  logic w_in_fill;
  logic w_in_run;
  logic w_in_hold;
  logic w_push;
  logic w_wr_last;
  logic w_tmo_last;

  assign w_in_fill  = (r_state == c_st_fill);
  assign w_in_run   = (r_state == c_st_run);
  assign w_in_hold  = (r_state == c_st_hold);
  assign w_push     = w_in_fill && pix_valid;
  assign w_wr_last  = (r_wr_cnt == c_wr_last);
  assign w_tmo_last = (r_tmo_cnt == c_tmo_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_st_fill;
      r_wr_cnt    <= '0;
      r_tmo_cnt   <= '0;
      r_res_value <= '0;
      r_res_err   <= 1'b0;
    end else begin
      case (r_state)
        c_st_fill: begin
          if (w_push) begin
            if (w_wr_last) begin
              r_wr_cnt  <= '0;
              r_tmo_cnt <= '0;
              r_state   <= c_st_run;
            end else begin
              r_wr_cnt <= r_wr_cnt + 1'b1;
            end
          end
        end
        c_st_run: begin
          // A done on the final timeout cycle still counts as success.
          if (cnn_done) begin
            r_res_value <= cnn_value;
            r_res_err   <= 1'b0;
            r_tmo_cnt   <= '0;
            r_state     <= c_st_hold;
          end else if (w_tmo_last) begin
            r_res_value <= '0;
            r_res_err   <= 1'b1;
            r_tmo_cnt   <= '0;
            r_state     <= c_st_hold;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        c_st_hold: begin
          if (res_ready) begin
            r_wr_cnt <= '0;
            r_state  <= c_st_fill;
          end
        end
        default: begin
          r_state <= c_st_fill;
        end
      endcase
    end
  end

  cnn_frame_buf #(
    .IMG_SIZE (IMG_SIZE),
    .DATA_W   (DATA_W),
    .ADDR_W   (WR_W)
  ) u_frame_buf (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_cnt),
    .i_wr_data (pix_data),
    .o_rd_bus  (img_bus)
  );

  assign pix_ready  = w_in_fill;
  assign cnn_enable = w_in_run;
  assign res_valid  = w_in_hold;
  assign res_value  = r_res_value;
  assign res_err    = r_res_err;

endmodule
`default_nettype wire

// File: tb/tb_cnn_img_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cnn_img_loader                                                  |
// | Randomized frame/result traffic against a transaction-level model. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_cnn_img_loader;

  localparam int IMG_SIZE = 64;
  localparam int DATA_W   = 32;
  localparam int OUT_W    = 32;
  localparam int TIMEOUT  = 16;

  logic                       clk;
  logic                       rst;
  logic [DATA_W-1:0]          pix_data;
  logic                       pix_valid;
  logic                       pix_ready;
  logic [IMG_SIZE*DATA_W-1:0] img_bus;
  logic                       cnn_enable;
  logic                       cnn_done;
  logic [OUT_W-1:0]           cnn_value;
  logic [OUT_W-1:0]           res_value;
  logic                       res_err;
  logic                       res_valid;
  logic                       res_ready;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] exp_frame [IMG_SIZE];
  logic              hold_valid = 1'b0;

  cnn_img_loader #(
    .IMG_SIZE (IMG_SIZE),
    .DATA_W   (DATA_W),
    .OUT_W    (OUT_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .img_bus    (img_bus),
    .cnn_enable (cnn_enable),
    .cnn_done   (cnn_done),
    .cnn_value  (cnn_value),
    .res_value  (res_value),
    .res_err    (res_err),
    .res_valid  (res_valid),
    .res_ready  (res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag);
    for (int k = 0; k < IMG_SIZE; k++) begin
      check_eq(tag, 64'(img_bus[k*DATA_W +: DATA_W]), 64'(exp_frame[k]));
    end
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps
  task automatic send_pixels(input int n, input int mode);
    int acc = 0;
    int cyc = 0;
    while (acc < n && cyc < 4*IMG_SIZE + 8) begin
      logic v;
      case (mode)
        0:       v = 1'b1;
        1:       v = ((cyc % 2) == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      pix_valid = v;
      pix_data  = v ? exp_frame[acc] : DATA_W'($urandom);
      check_eq("fill_ready", 64'(pix_ready), 64'(1));
      tick();
      if (v) acc++;
      cyc++;
      if (acc < IMG_SIZE) check_eq("no_early_run", 64'(cnn_enable), 64'(0));
    end
    if (acc < n) check_eq("fill_budget", 64'(acc), 64'(n));
    pix_valid = hold_valid;
    pix_data  = DATA_W'($urandom);
    if (n == IMG_SIZE) begin
      check_eq("run_enable", 64'(cnn_enable), 64'(1));
      check_eq("run_not_ready", 64'(pix_ready), 64'(0));
      check_frame("img_slot");
    end
  endtask

  // done_dly: RUN-cycle index of cnn_done, or <0 / >=TIMEOUT for none
  task automatic run_phase(input int done_dly, input logic [OUT_W-1:0] val, input int ready_dly);
    int cnt = 0;
    bit by_done;
    logic [OUT_W-1:0] exp_val;
    by_done = (done_dly >= 0) && (done_dly < TIMEOUT);
    exp_val = by_done ? val : '0;
    while (cnn_enable && cnt < TIMEOUT + 4) begin
      cnn_done  = (cnt == done_dly);
      cnn_value = (cnt == done_dly) ? val : OUT_W'($urandom);
      pix_valid = hold_valid;
      pix_data  = DATA_W'($urandom);
      check_eq("run_no_valid", 64'(res_valid), 64'(0));
      check_eq("run_no_ready", 64'(pix_ready), 64'(0));
      tick();
      cnt++;
    end
    cnn_done = 1'b0;
    check_eq("run_len", 64'(cnt), 64'(by_done ? done_dly + 1 : TIMEOUT));
    for (int h = 0; h <= ready_dly; h++) begin
      res_ready = (h == ready_dly);
      cnn_value = OUT_W'($urandom);
      pix_valid = hold_valid;
      pix_data  = DATA_W'($urandom);
      check_eq("hold_valid", 64'(res_valid), 64'(1));
      check_eq("hold_value", 64'(res_value), 64'(exp_val));
      check_eq("hold_err", 64'(res_err), 64'(!by_done));
      check_eq("hold_enable", 64'(cnn_enable), 64'(0));
      check_eq("hold_not_ready", 64'(pix_ready), 64'(0));
      tick();
    end
    res_ready = 1'b0;
    pix_valid = 1'b0;
    check_eq("back_valid", 64'(res_valid), 64'(0));
    check_eq("back_ready", 64'(pix_ready), 64'(1));
    check_eq("back_enable", 64'(cnn_enable), 64'(0));
    check_frame("buf_kept");
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 64'(pix_ready), 64'(1));
    check_eq({tag, "_enable"}, 64'(cnn_enable), 64'(0));
    check_eq({tag, "_valid"}, 64'(res_valid), 64'(0));
    check_eq({tag, "_value"}, 64'(res_value), 64'(0));
    check_eq({tag, "_err"}, 64'(res_err), 64'(0));
  endtask

  initial begin
    rst       = 1'b0;
    pix_data  = '0;
    pix_valid = 1'b0;
    cnn_done  = 1'b0;
    cnn_value = '0;
    res_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst");
    tick();
    rst = 1'b0;

    // all-ones frame, done three cycles after enable rises
    for (int k = 0; k < IMG_SIZE; k++) exp_frame[k] = DATA_W'(1);
    send_pixels(IMG_SIZE, 0);
    run_phase(3, OUT_W'(7), 0);

    // pixel k = k, toggling valid, valid held in RUN/HOLD, timeout, slow ready
    for (int k = 0; k < IMG_SIZE; k++) exp_frame[k] = DATA_W'(k);
    hold_valid = 1'b1;
    send_pixels(IMG_SIZE, 1);
    run_phase(-1, OUT_W'(0), 5);
    hold_valid = 1'b0;

    // done coincides with the final timeout cycle
    for (int k = 0; k < IMG_SIZE; k++) exp_frame[k] = DATA_W'($urandom);
    send_pixels(IMG_SIZE, 2);
    run_phase(TIMEOUT - 1, OUT_W'($urandom), 1);

    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < IMG_SIZE; k++) exp_frame[k] = DATA_W'($urandom);
      hold_valid = 1'($urandom_range(0, 1));
      send_pixels(IMG_SIZE, int'($urandom_range(0, 2)));
      run_phase(int'($urandom_range(0, TIMEOUT + 3)), OUT_W'($urandom),
                int'($urandom_range(0, 3)));
    end
    hold_valid = 1'b0;

    // reset after 30 pixels, then a fresh frame
    for (int k = 0; k < IMG_SIZE; k++) exp_frame[k] = DATA_W'($urandom);
    send_pixels(30, 0);
    rst = 1'b1;
    #1 check_reset_outputs("rst_fill");
    #2 rst = 1'b0;
    for (int k = 0; k < IMG_SIZE; k++) exp_frame[k] = DATA_W'($urandom);
    send_pixels(IMG_SIZE, 2);
    run_phase(int'($urandom_range(0, TIMEOUT - 1)), OUT_W'($urandom), 0);

    // reset mid-RUN: no result may appear afterwards
    send_pixels(IMG_SIZE, 0);
    for (int c = 0; c < 3; c++) tick();
    rst = 1'b1;
    #1 check_reset_outputs("rst_run");
    #2 rst = 1'b0;
    for (int c = 0; c < TIMEOUT + 4; c++) begin
      tick();
      check_eq("no_res_after_rst", 64'(res_valid), 64'(0));
      check_eq("fill_after_rst", 64'(pix_ready), 64'(1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cnn_img_loader.md
CNN_IMG_LOADER -- requirements
Module: cnn_img_loader

Interface
REQ-001 Parameter IMG_SIZE, default 64, pixels per frame.
REQ-002 Parameter DATA_W, default 32, pixel width in bits.
REQ-003 Parameter OUT_W, default 32, CNN result width in bits.
REQ-004 Parameter TIMEOUT, default 1024, maximum RUN cycles before abort.
REQ-005 Port clk, input, 1, single clock; all logic on rising edge.
REQ-006 Port rst, input, 1, asynchronous active-high reset.
REQ-007 Port pix_data, input, DATA_W, incoming pixel.
REQ-008 Port pix_valid, input, 1, pix_data valid.
REQ-009 Port pix_ready, output, 1, loader accepts a pixel this cycle.
REQ-010 Port img_bus, output, IMG_SIZE*DATA_W, frame to cnn_top; pixel k occupies bits [k*DATA_W +: DATA_W].
REQ-011 Port cnn_enable, output, 1, drives cnn_top enable.
REQ-012 Port cnn_done, input, 1, cnn_top done.
REQ-013 Port cnn_value, input, OUT_W, cnn_top value.
REQ-014 Port res_value, output, OUT_W, captured prediction.
REQ-015 Port res_err, output, 1, result produced by timeout, not cnn_done.
REQ-016 Port res_valid, output, 1, result available.
REQ-017 Port res_ready, input, 1, downstream accepts the result.

Function
REQ-018 FSM states FILL, RUN, HOLD; FILL follows reset.
REQ-019 FILL: pix_ready=1; a transfer occurs on a cycle with pix_valid=1 and pix_ready=1; it writes buffer[wr_cnt] and increments wr_cnt.
REQ-020 Frame complete: the transfer at wr_cnt=IMG_SIZE-1 moves the FSM to RUN on the next cycle and wraps wr_cnt to 0; pixel IMG_SIZE is never written.
REQ-021 pix_ready=0 in RUN and HOLD; pix_valid is ignored there.
REQ-022 img_bus reflects buffer contents combinationally and stays stable outside FILL.
REQ-023 RUN: cnn_enable=1; tmo_cnt increments each RUN cycle from 0.
REQ-024 RUN with cnn_done=1: cnn_value is captured into res_value, res_err is set to 0, and the FSM moves to HOLD.
REQ-025 RUN with tmo_cnt=TIMEOUT-1 and cnn_done=0: res_value is set to 0, res_err to 1, and the FSM moves to HOLD.
REQ-026 cnn_done and timeout in the same cycle: done wins and res_err=0.
REQ-027 HOLD: cnn_enable=0 and res_valid=1; res_value and res_err are held stable until the handshake.
REQ-028 HOLD with res_ready=1: the result is consumed; next cycle the FSM is in FILL, res_valid=0, wr_cnt=0.
REQ-029 res_ready=1 on the first HOLD cycle is accepted, giving 1 cycle of res_valid.
REQ-030 Latency: last pixel accepted at cycle N gives cnn_enable=1 at N+1; cnn_done at cycle M gives res_valid=1 at M+1.
REQ-031 Buffer contents persist across frames; each frame fully overwrites all IMG_SIZE entries.

Reset
REQ-032 rst=1 asynchronously forces: state FILL, wr_cnt=0, tmo_cnt=0, cnn_enable=0, res_valid=0, res_value=0, res_err=0, pix_ready=1 after release.
REQ-033 Buffer storage is not reset; img_bus is don't-care until the first frame completes.
REQ-034 Reset mid-FILL or mid-RUN discards the partial frame or pending result; no res_valid follows.

Structure
REQ-035 Package cnn_pkg holds IMG_SIZE, DATA_W, OUT_W defaults and the FSM state enum, shared with cnn_top.
REQ-036 Storage is one sub-module, cnn_frame_buf (IMG_SIZE x DATA_W, single write port, flat read bus); FSM and counters live in cnn_img_loader.

Verification
REQ-037 Scenario: 64 pixels of value 1 back-to-back, cnn_done with cnn_value=7 three cycles after cnn_enable rises -> res_value=7, res_err=0, res_valid one cycle after done.
REQ-038 Scenario: pixel k=k with pix_valid toggling every other cycle -> 64 accepted, img_bus slot k = k, RUN entered only after the 64th.
REQ-039 Scenario: pix_valid held high during RUN/HOLD -> pix_ready=0, buffer unchanged.
REQ-040 Scenario: cnn_done never asserted, TIMEOUT=16 -> res_valid after 16 RUN cycles, res_value=0, res_err=1.
REQ-041 Scenario: res_ready low 5 cycles in HOLD -> res_value stable and res_valid high for all 5; the 6th-cycle handshake returns the FSM to FILL.
REQ-042 Scenario: rst pulsed after 30 pixels -> wr_cnt=0, cnn_enable=0, and the next 64 pixels form a fresh frame.
